// File: rtl/recharge_ctrl.sv
// ============================================================================
//  Module   : recharge_ctrl
//  Purpose  : Prepaid-balance top-up front end with a digit-serial BCD adder.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module recharge_ctrl #(
    parameter int TICK_CYC  = 100000000,
    parameter int TIMEOUT_S = 8,
    parameter int SHOW_S    = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        on,
    input  logic        bt_digit,
    input  logic        bt_ok,
    input  logic        bt_cancel,
    input  logic [3:0]  digit_sw,
    input  logic [11:0] bal_in,
    output logic [11:0] bal_out,
    output logic        bal_we,
    output logic [15:0] disp,
    output logic [7:0]  st_light
);

    localparam int SEC_W  = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int SECS_W = 8;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_ENTRY = 3'd1;
    localparam logic [2:0] S_ADD   = 3'd2;
    localparam logic [2:0] S_DONE  = 3'd3;
    localparam logic [2:0] S_ERR   = 3'd4;

    logic [2:0]        state_q, state_d;
    logic [11:0]       amt_q, amt_d;
    logic [1:0]        cnt_q, cnt_d;
    logic [11:0]       acc_q, acc_d;
    logic              carry_q, carry_d;
    logic [1:0]        idx_q, idx_d;
    logic [SEC_W-1:0]  tick_cnt_q, tick_cnt_d;
    logic [SECS_W-1:0] secs_q, secs_d;
    logic [11:0]       bal_out_q, bal_out_d;
    logic              bal_we_q, bal_we_d;

    // Cancel beats ok beats digit; an out-of-range digit is never a winner.
    logic w_win_cancel, w_win_ok, w_win_digit, w_tick, w_restart;
    logic [4:0] w_sum;
    logic [3:0] w_sum_digit;

    assign w_win_cancel = bt_cancel;
    assign w_win_ok     = bt_ok & ~bt_cancel;
    assign w_win_digit  = bt_digit & ~bt_ok & ~bt_cancel & (digit_sw <= 4'd9);
    assign w_tick       = (tick_cnt_q == SEC_W'(TICK_CYC - 1));

    assign w_sum       = {1'b0, acc_q[3:0]} + {1'b0, amt_q[3:0]} + {4'b0000, carry_q};
    assign w_sum_digit = (w_sum > 5'd9) ? 4'(w_sum - 5'd10) : w_sum[3:0];

    always_ff @(posedge clk) begin
        if (rst || !on) begin
            state_q    <= S_IDLE;
            amt_q      <= 12'h000;
            cnt_q      <= 2'd0;
            acc_q      <= 12'h000;
            carry_q    <= 1'b0;
            idx_q      <= 2'd0;
            tick_cnt_q <= '0;
            secs_q     <= '0;
            bal_out_q  <= 12'h000;
            bal_we_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            amt_q      <= amt_d;
            cnt_q      <= cnt_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            idx_q      <= idx_d;
            tick_cnt_q <= tick_cnt_d;
            secs_q     <= secs_d;
            bal_out_q  <= bal_out_d;
            bal_we_q   <= bal_we_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        amt_d      = amt_q;
        cnt_d      = cnt_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        idx_d      = idx_q;
        bal_out_d  = bal_out_q;
        bal_we_d   = 1'b0;
        w_restart  = 1'b0;
        tick_cnt_d = w_tick ? '0 : tick_cnt_q + SEC_W'(1);
        secs_d     = w_tick ? secs_q + SECS_W'(1) : secs_q;

        case (state_q)
            S_IDLE: begin
                if (w_win_digit) begin
                    amt_d   = {8'h00, digit_sw};
                    cnt_d   = 2'd1;
                    state_d = S_ENTRY;
                end
            end
            S_ENTRY: begin
                if (w_win_cancel) begin
                    amt_d   = 12'h000;
                    state_d = S_IDLE;
                end else if (w_win_ok) begin
                    if (amt_q == 12'h000) begin
                        state_d = S_ERR;
                    end else begin
                        acc_d   = bal_in;
                        carry_d = 1'b0;
                        idx_d   = 2'd0;
                        state_d = S_ADD;
                    end
                end else if (w_win_digit) begin
                    w_restart = 1'b1;
                    if (cnt_q < 2'd3) begin
                        amt_d = {amt_q[7:0], digit_sw};
                        cnt_d = cnt_q + 2'd1;
                    end
                end else if (w_tick && secs_q == SECS_W'(TIMEOUT_S - 1)) begin
                    amt_d   = 12'h000;
                    state_d = S_IDLE;
                end
            end
            S_ADD: begin
                // acc and amt rotate one digit per cycle, so three passes
                // leave both back in {hundreds, tens, ones} order.
                if (idx_q == 2'd3) begin
                    if (carry_q) begin
                        state_d = S_ERR;
                    end else begin
                        bal_we_d  = 1'b1;
                        bal_out_d = acc_q;
                        state_d   = S_DONE;
                    end
                end else begin
                    acc_d   = {w_sum_digit, acc_q[11:4]};
                    amt_d   = {amt_q[3:0], amt_q[11:4]};
                    carry_d = (w_sum > 5'd9);
                    idx_d   = idx_q + 2'd1;
                end
            end
            S_DONE: begin
                if (w_win_digit) begin
                    amt_d   = {8'h00, digit_sw};
                    cnt_d   = 2'd1;
                    state_d = S_ENTRY;
                end else if (w_tick && secs_q == SECS_W'(SHOW_S - 1)) begin
                    amt_d   = 12'h000;
                    state_d = S_IDLE;
                end
            end
            S_ERR: begin
                if (w_tick && secs_q == SECS_W'(SHOW_S - 1)) begin
                    amt_d   = 12'h000;
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (state_d != state_q || w_restart) begin
            tick_cnt_d = '0;
            secs_d     = '0;
        end
    end

    always_comb begin
        st_light = 8'd1 << state_q;
        case (state_q)
            S_ENTRY: disp = {4'd11, amt_q};
            S_DONE:  disp = {4'd11, bal_out_q};
            S_ERR:   disp = {4'd10, 4'd10, 4'd10, 4'd10};
            default: disp = {4'd11, bal_in};
        endcase
    end

    assign bal_out = bal_out_q;
    assign bal_we  = bal_we_q;

endmodule

`default_nettype wire

// File: tb/tb_recharge_ctrl.sv
// ============================================================================
//  Module   : tb_recharge_ctrl
//  Purpose  : Directed, table-driven bench for recharge_ctrl (TICK_CYC = 10).
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_recharge_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        on = 1'b1;
    logic        bt_digit = 1'b0;
    logic        bt_ok = 1'b0;
    logic        bt_cancel = 1'b0;
    logic [3:0]  digit_sw = 4'd0;
    logic [11:0] bal_in = 12'h196;
    logic [11:0] bal_out;
    logic        bal_we;
    logic [15:0] disp;
    logic [7:0]  st_light;

    int checks = 0;
    int errors = 0;

    recharge_ctrl #(.TICK_CYC(10), .TIMEOUT_S(8), .SHOW_S(2)) dut (
        .clk(clk), .rst(rst), .on(on), .bt_digit(bt_digit), .bt_ok(bt_ok),
        .bt_cancel(bt_cancel), .digit_sw(digit_sw), .bal_in(bal_in),
        .bal_out(bal_out), .bal_we(bal_we), .disp(disp), .st_light(st_light)
    );

    always #5 clk = ~clk;

    // control word {rst, on, bt_digit, bt_ok, bt_cancel}
    localparam logic [4:0] C_IDLE  = 5'b01000;
    localparam logic [4:0] C_DIG   = 5'b01100;
    localparam logic [4:0] C_OK    = 5'b01010;
    localparam logic [4:0] C_CAN   = 5'b01001;
    localparam logic [4:0] C_OKCAN = 5'b01011;
    localparam logic [4:0] C_RST   = 5'b11000;
    localparam logic [4:0] C_OFF   = 5'b00000;
    localparam logic [4:0] C_OFFD  = 5'b00100;

    localparam logic [7:0] L_IDLE = 8'h01, L_ENTRY = 8'h02, L_ADD = 8'h04,
                           L_DONE = 8'h08, L_ERR = 8'h10;
    localparam logic [15:0] DC = 16'hFFFF;

    typedef struct {
        logic [4:0]  ctl;
        logic [3:0]  d;
        logic [11:0] bal;
        logic [7:0]  st;
        logic [15:0] disp;
        logic        we;
        logic [11:0] bo;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t V(logic [4:0] ctl, logic [3:0] d, logic [11:0] bal,
                               logic [7:0] st, logic [15:0] dsp, logic we, logic [11:0] bo);
        vec_t v;
        v.ctl = ctl; v.d = d; v.bal = bal; v.st = st; v.disp = dsp; v.we = we; v.bo = bo;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic [4:0] ctl, input logic [3:0] d, input logic [11:0] bal);
        @(negedge clk);
        {rst, on, bt_digit, bt_ok, bt_cancel} = ctl;
        digit_sw = d;
        bal_in   = bal;
        @(posedge clk);
        #1;
    endtask

    task automatic run_tbl(input string tag);
        foreach (tbl[i]) begin
            drive(tbl[i].ctl, tbl[i].d, tbl[i].bal);
            chk({tag, ".st"}, st_light, tbl[i].st);
            if (tbl[i].disp != DC) chk({tag, ".disp"}, disp, tbl[i].disp);
            chk({tag, ".we"}, bal_we, tbl[i].we);
            chk({tag, ".bal_out"}, bal_out, tbl[i].bo);
        end
        tbl.delete();
    endtask

    task automatic idle_run(input int n, input logic [7:0] st, input logic [11:0] bal, input string tag);
        for (int k = 0; k < n; k++) begin
            drive(C_IDLE, 4'd0, bal);
            chk({tag, ".hold_st"}, st_light, st);
            chk({tag, ".we_low"}, bal_we, 1'b0);
        end
    endtask

    initial begin
        // Top-up 050 onto 196; write 246 four cycles after ok
        tbl.push_back(V(C_RST, 0, 12'h196, L_IDLE,  16'hB196, 0, 12'h000));
        tbl.push_back(V(C_DIG, 5, 12'h196, L_ENTRY, 16'hB005, 0, 12'h000));
        tbl.push_back(V(C_DIG, 0, 12'h196, L_ENTRY, 16'hB050, 0, 12'h000));
        tbl.push_back(V(C_OK,  0, 12'h196, L_ADD,   DC,       0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h196, L_ADD,   DC,       0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h196, L_ADD,   DC,       0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h196, L_ADD,   DC,       0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h196, L_DONE,  16'hB246, 1, 12'h246));
        tbl.push_back(V(C_IDLE,0, 12'h196, L_DONE,  16'hB246, 0, 12'h246));
        run_tbl("add246");
        idle_run(18, L_DONE, 12'h196, "done_show");
        tbl.push_back(V(C_IDLE,0, 12'h196, L_IDLE,  16'hB196, 0, 12'h246));

        // Four digits (4th dropped), invalid digit, cancel, then priority and zero amount
        tbl.push_back(V(C_DIG, 1, 12'h196, L_ENTRY, 16'hB001, 0, 12'h246));
        tbl.push_back(V(C_DIG, 2, 12'h196, L_ENTRY, 16'hB012, 0, 12'h246));
        tbl.push_back(V(C_DIG, 3, 12'h196, L_ENTRY, 16'hB123, 0, 12'h246));
        tbl.push_back(V(C_DIG, 4, 12'h196, L_ENTRY, 16'hB123, 0, 12'h246));
        tbl.push_back(V(C_DIG, 12,12'h196, L_ENTRY, 16'hB123, 0, 12'h246));
        tbl.push_back(V(C_CAN, 0, 12'h196, L_IDLE,  16'hB196, 0, 12'h246));
        tbl.push_back(V(C_DIG, 9, 12'h196, L_ENTRY, 16'hB009, 0, 12'h246));
        tbl.push_back(V(C_OKCAN,0,12'h196, L_IDLE,  16'hB196, 0, 12'h246));
        tbl.push_back(V(C_DIG, 0, 12'h196, L_ENTRY, 16'hB000, 0, 12'h246));
        tbl.push_back(V(C_DIG, 0, 12'h196, L_ENTRY, 16'hB000, 0, 12'h246));
        tbl.push_back(V(C_OK,  0, 12'h196, L_ERR,   16'hAAAA, 0, 12'h246));
        tbl.push_back(V(C_DIG, 3, 12'h196, L_ERR,   16'hAAAA, 0, 12'h246));
        run_tbl("entry");
        idle_run(18, L_ERR, 12'h196, "err_zero");
        tbl.push_back(V(C_IDLE,0, 12'h196, L_IDLE,  16'hB196, 0, 12'h246));

        // 999 + 001 overflows out of the hundreds digit
        tbl.push_back(V(C_DIG, 1, 12'h999, L_ENTRY, 16'hB001, 0, 12'h246));
        tbl.push_back(V(C_OK,  0, 12'h999, L_ADD,   DC,       0, 12'h246));
        tbl.push_back(V(C_IDLE,0, 12'h999, L_ADD,   DC,       0, 12'h246));
        tbl.push_back(V(C_IDLE,0, 12'h999, L_ADD,   DC,       0, 12'h246));
        tbl.push_back(V(C_IDLE,0, 12'h999, L_ADD,   DC,       0, 12'h246));
        tbl.push_back(V(C_IDLE,0, 12'h999, L_ERR,   16'hAAAA, 0, 12'h246));
        run_tbl("ovf999");
        idle_run(19, L_ERR, 12'h999, "err_ovf");
        tbl.push_back(V(C_IDLE,0, 12'h999, L_IDLE,  16'hB999, 0, 12'h246));

        // Timeout without activity, landing exactly 80 cycles after entry
        tbl.push_back(V(C_DIG, 7, 12'h196, L_ENTRY, 16'hB007, 0, 12'h246));
        run_tbl("to_a");
        idle_run(79, L_ENTRY, 12'h196, "to_wait");
        tbl.push_back(V(C_IDLE,0, 12'h196, L_IDLE,  16'hB196, 0, 12'h246));
        tbl.push_back(V(C_DIG, 7, 12'h196, L_ENTRY, 16'hB007, 0, 12'h246));
        run_tbl("to_b");
        idle_run(51, L_ENTRY, 12'h196, "to_pre");
        tbl.push_back(V(C_DIG, 2, 12'h196, L_ENTRY, 16'hB072, 0, 12'h246));
        run_tbl("to_c");
        idle_run(79, L_ENTRY, 12'h196, "to_restart");
        tbl.push_back(V(C_IDLE,0, 12'h196, L_IDLE,  16'hB196, 0, 12'h246));

        // Reset and power-off in the middle of ADD
        tbl.push_back(V(C_DIG, 5, 12'h196, L_ENTRY, 16'hB005, 0, 12'h246));
        tbl.push_back(V(C_OK,  0, 12'h196, L_ADD,   DC,       0, 12'h246));
        tbl.push_back(V(C_IDLE,0, 12'h196, L_ADD,   DC,       0, 12'h246));
        tbl.push_back(V(C_RST, 0, 12'h196, L_IDLE,  16'hB196, 0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h196, L_IDLE,  16'hB196, 0, 12'h000));
        tbl.push_back(V(C_DIG, 5, 12'h196, L_ENTRY, 16'hB005, 0, 12'h000));
        tbl.push_back(V(C_OK,  0, 12'h196, L_ADD,   DC,       0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h196, L_ADD,   DC,       0, 12'h000));
        tbl.push_back(V(C_OFF, 0, 12'h196, L_IDLE,  16'hB196, 0, 12'h000));
        tbl.push_back(V(C_OFFD,5, 12'h196, L_IDLE,  16'hB196, 0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h196, L_IDLE,  16'hB196, 0, 12'h000));

        // 955 + 045 overflows to 1000
        tbl.push_back(V(C_DIG, 4, 12'h955, L_ENTRY, 16'hB004, 0, 12'h000));
        tbl.push_back(V(C_DIG, 5, 12'h955, L_ENTRY, 16'hB045, 0, 12'h000));
        tbl.push_back(V(C_OK,  0, 12'h955, L_ADD,   DC,       0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h955, L_ADD,   DC,       0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h955, L_ADD,   DC,       0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h955, L_ADD,   DC,       0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h955, L_ERR,   16'hAAAA, 0, 12'h000));
        run_tbl("ovf1000");
        idle_run(19, L_ERR, 12'h955, "err_1000");

        // 955 + 044 writes 999; a digit in DONE restarts entry
        tbl.push_back(V(C_IDLE,0, 12'h955, L_IDLE,  16'hB955, 0, 12'h000));
        tbl.push_back(V(C_DIG, 4, 12'h955, L_ENTRY, 16'hB004, 0, 12'h000));
        tbl.push_back(V(C_DIG, 4, 12'h955, L_ENTRY, 16'hB044, 0, 12'h000));
        tbl.push_back(V(C_OK,  0, 12'h955, L_ADD,   DC,       0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h955, L_ADD,   DC,       0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h955, L_ADD,   DC,       0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h955, L_ADD,   DC,       0, 12'h000));
        tbl.push_back(V(C_IDLE,0, 12'h955, L_DONE,  16'hB999, 1, 12'h999));
        tbl.push_back(V(C_IDLE,0, 12'h955, L_DONE,  16'hB999, 0, 12'h999));
        tbl.push_back(V(C_DIG, 1, 12'h955, L_ENTRY, 16'hB001, 0, 12'h999));
        tbl.push_back(V(C_CAN, 0, 12'h955, L_IDLE,  16'hB955, 0, 12'h999));
        run_tbl("add999");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/recharge_ctrl.md
Name: recharge_ctrl

Overview:
- Top-up front end for the washer's prepaid balance. It is the writer side of the 3-digit BCD balance that the billing logic reads and deducts from.
- User keys a 3-digit BCD amount one digit at a time, then confirms. The block does a digit-serial BCD add onto the current balance and issues a one-cycle write strobe with the new balance.
- Overflow past 999 is rejected with an error display. The block drives the 4-digit display code bus and the state lights while active.

Parameters:
- TICK_CYC, 100000000: clk cycles per 1 s tick. Benches use 10.
- TIMEOUT_S, 8: idle seconds in ENTRY before abandoning entry.
- SHOW_S, 2: seconds DONE and ERR are displayed.

Ports:
- clk  in  1  system clock.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- on  in  1  machine power; low forces IDLE.
- bt_digit  in  1  one-cycle pulse (pre-debounced): shift in digit_sw.
- bt_ok  in  1  one-cycle pulse: confirm amount.
- bt_cancel  in  1  one-cycle pulse: abandon entry.
- digit_sw  in  4  digit value; only 0..9 are valid.
- bal_in  in  12  current balance, BCD {hundreds, tens, ones}.
- bal_out  out  12  new balance, BCD; valid when bal_we=1.
- bal_we  out  1  one-cycle write strobe.
- disp  out  16  display codes {n0,n3,n2,n1}. Code 0-9 = digit, 10 = '-', 11 = blank.
- st_light  out  8  one-hot state indicator.

Behaviour:
- Reset (rst=1 at posedge): state=IDLE, amt=000, cnt=0, sec counter=0, carry=0, bal_out=000, bal_we=0, disp={11,bal_in}, st_light=8'b00000001.
- on=0: same effect as reset on the next edge, except no output is held. No write ever occurs with on=0.
- Button priority when pulses coincide in one cycle: cancel > ok > digit. Only the winning pulse is acted on.
- Digit validity: a digit_sw value >9 makes bt_digit ignored entirely. No shift, and the timeout is not restarted.
- Seconds tick: counter 0..TICK_CYC-1 produces a 1-cycle pulse. It clears on every state change and on every accepted button in ENTRY.
- IDLE:
  - disp={11,bal_in}.
  - A valid bt_digit sets amt={0,0,d} and cnt=1, then goes to ENTRY.
  - bt_ok and bt_cancel are ignored.
- ENTRY:
  - disp={11,amt}; st_light=8'b00000010.
  - Valid bt_digit with cnt<3: amt<={amt[7:0],d}, cnt+1.
  - Valid bt_digit with cnt=3: digit ignored, but the timeout still restarts.
  - bt_cancel: amt=000, go to IDLE.
  - bt_ok with amt=000: go to ERR.
  - bt_ok with amt!=000: latch bal_in into acc, clear carry, go to ADD.
  - TIMEOUT_S ticks with no accepted button: amt=000, go to IDLE.
- ADD (st_light=8'b00000100): exactly 3 cycles, ones, then tens, then hundreds.
  - Each cycle: s=acc_digit+amt_digit+carry.
  - If s>9: digit=s-10 (i.e. s+6 mod 16), carry=1. Otherwise digit=s, carry=0.
  - Buttons are ignored during ADD; on=0 still aborts it.
  - On the cycle after the hundreds digit:
    - carry=1: go to ERR with no write.
    - carry=0: bal_we=1 for exactly one cycle, bal_out=acc, go to DONE.
  - Latency: bt_ok at edge T gives bal_we high during cycle T+4.
- DONE:
  - disp={11,bal_out}; st_light=8'b00001000.
  - After SHOW_S ticks: go to IDLE, amt=000.
  - A valid bt_digit starts a new ENTRY immediately.
- ERR:
  - disp={10,10,10,10}; st_light=8'b00010000.
  - After SHOW_S ticks: go to IDLE, amt=000.
  - All buttons are ignored.
- bal_out holds its last written value between strobes. bal_we is 0 in every state except the single strobe cycle.

Test Plan:
- bal_in=196; digits 5,0 then ok -> ENTRY disp={11,0,5,0}; 4 cycles after ok, one bal_we pulse with bal_out=246; DONE for 2 ticks; then IDLE disp={11,1,9,6}.
- bal_in=999; digit 1, ok -> ADD carries out of hundreds -> ERR disp all 10, bal_we never asserted; IDLE after 2 ticks.
- Digits 1,2,3,4 -> amt=123 (4th ignored). Digit_sw=12 pulse -> no change. Then cancel -> IDLE, amt=000, no write.
- Digit 7 then no input for 8 ticks -> IDLE, no write. A 5th-tick digit restarts the count, so the timeout lands 8 ticks after it.
- bt_ok and bt_cancel in the same cycle in ENTRY -> cancel wins. bt_ok with amt=000 (digits 0,0) -> ERR.
- Mid-ADD, rst=1 or on=0 -> next cycle IDLE, bal_we=0, outputs at reset values. Amount 045 onto 955 -> ERR (1000 overflow). Amount 044 onto 955 -> write 999.
